// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : button_pkg
//  Description : Shared types, helper function and default parameter values
//                for the button_bank multi-channel button conditioner.
//  Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

  // Per-channel long-press state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } hold_state_t;

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int DEF_N_BTN           = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 650000;
  localparam int DEF_HOLD_CYCLES     = 50000000;
  localparam int DEF_REPEAT_CYCLES   = 10000000;

endpackage : button_pkg
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ============================================================================
//  Module      : button_channel
//  Description : One button channel: two-flop synchroniser, debouncer,
//                registered press/release strobes and, when the macro
//                BUTTON_BANK_REPEAT_EN is defined, a long-press auto-repeat
//                FSM. Without the macro repeat_o is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int DW = cnt_w(DEBOUNCE_CYCLES);

  logic          s0_q, s1_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  // Debounce next state: count while the synchronised input disagrees with
  // the clean level; any agreement (a bounce) restarts the count from zero.
  always_comb begin
    dcnt_d    = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (s1_q != level_q) begin
      if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        level_d   = s1_q;
        press_d   = s1_q;
        release_d = ~s1_q;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  // Synchroniser, debounce counter, clean level and edge strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      dcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s0_q      <= raw_i;
      s1_q      <= s0_q;
      dcnt_q    <= dcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef BUTTON_BANK_REPEAT_EN
  // One counter serves both the initial hold delay and the repeat period.
  localparam int HW = cnt_w((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);

  hold_state_t   state_q;
  logic [HW-1:0] hcnt_q;
  logic          repeat_q;

  // Hold FSM: release edge wins over a repeat that falls due on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hcnt_q   <= '0;
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= 1'b0;
      case (state_q)
        IDLE: begin
          hcnt_q <= '0;
          if (press_d) begin
            state_q <= HELD;
          end
        end
        HELD: begin
          if (release_d) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
          end else if (hcnt_q == HW'(HOLD_CYCLES - 1)) begin
            state_q  <= REPEAT;
            hcnt_q   <= '0;
            repeat_q <= 1'b1;
          end else begin
            hcnt_q <= hcnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (release_d) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
          end else if (hcnt_q == HW'(REPEAT_CYCLES - 1)) begin
            hcnt_q   <= '0;
            repeat_q <= 1'b1;
          end else begin
            hcnt_q <= hcnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          hcnt_q  <= '0;
        end
      endcase
    end
  end

  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

endmodule : button_channel
`default_nettype wire

// File: rtl/button_bank.sv
`default_nettype none
// ============================================================================
//  Module      : button_bank
//  Description : Bank of N_BTN independent button conditioners producing a
//                debounced level plus press, release and (optionally)
//                auto-repeat strobes per channel. Auto-repeat is compiled in
//                only when BUTTON_BANK_REPEAT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_bank
  import button_pkg::*;
#(
  parameter int N_BTN           = DEF_N_BTN,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] raw_in,
  output logic [N_BTN-1:0] level_out,
  output logic [N_BTN-1:0] press_out,
  output logic [N_BTN-1:0] release_out,
  output logic [N_BTN-1:0] repeat_out
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .raw_i     (raw_in[i]),
      .level_o   (level_out[i]),
      .press_o   (press_out[i]),
      .release_o (release_out[i]),
      .repeat_o  (repeat_out[i])
    );
  end

endmodule : button_bank
`default_nettype wire

// File: tb/tb_button_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_bank
//  Description : Directed self-checking bench for button_bank with
//                N_BTN=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.
//                Expected repeat strobes depend on BUTTON_BANK_REPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_bank;

  localparam int N  = 2;
  localparam int DB = 4;
  localparam int HC = 10;
  localparam int RC = 3;
`ifdef BUTTON_BANK_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] raw_in = '0;
  logic [N-1:0] level_out, press_out, release_out, repeat_out;

  int edge_cnt = 0;
  int n_tests  = 0;
  int n_fail   = 0;

  button_bank #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (DB),
    .HOLD_CYCLES     (HC),
    .REPEAT_CYCLES   (RC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .raw_in      (raw_in),
    .level_out   (level_out),
    .press_out   (press_out),
    .release_out (release_out),
    .repeat_out  (repeat_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  // Stimulus helper only: puts the DUT into a known idle state.
  task automatic apply_reset();
    rst    = 1'b1;
    raw_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [4*N-1:0] got;
    rst    = 1'b1;
    raw_in = '1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      got = {level_out, press_out, release_out, repeat_out};
      n_tests++;
      if (got !== '0) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got=%b exp=%b", i, got, {(4*N){1'b0}});
      end
    end
    apply_reset();
  endtask

  task automatic test_clean_press();
    int k, d;
    logic [N-1:0]   el, ep, er, et;
    logic [4*N-1:0] got, exp;
    apply_reset();
    raw_in[0] = 1'b1;
    k = edge_cnt + 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      d  = edge_cnt - k;
      el = {1'b0, (d >= 5 && d < 13)};
      ep = {1'b0, (d == 5)};
      er = {1'b0, (d == 13)};
      et = '0;
      got = {level_out, press_out, release_out, repeat_out};
      exp = {el, ep, er, et};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL clean_press d=%0d got=%b exp=%b", d, got, exp);
      end
      if (d == 7) raw_in[0] = 1'b0;
    end
  endtask

  task automatic test_bounce();
    int k, d;
    logic [N-1:0]   el, ep, er, et;
    logic [4*N-1:0] got, exp;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      raw_in[0] = ((i % 4) != 3);
      @(negedge clk);
      got = {level_out, press_out, release_out, repeat_out};
      n_tests++;
      if (got !== '0) begin
        n_fail++;
        $display("FAIL bounce i=%0d got=%b exp=%b", i, got, {(4*N){1'b0}});
      end
    end
    raw_in[0] = 1'b1;
    k = edge_cnt + 1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      d  = edge_cnt - k;
      el = {1'b0, (d >= 5 && d < 12)};
      ep = {1'b0, (d == 5)};
      er = {1'b0, (d == 12)};
      et = '0;
      got = {level_out, press_out, release_out, repeat_out};
      exp = {el, ep, er, et};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL bounce_settle d=%0d got=%b exp=%b", d, got, exp);
      end
      if (d == 6) raw_in[0] = 1'b0;
    end
  endtask

  // Press at d=5; repeats at d=15,18,21; release edge at d=24 where a repeat
  // would also be due.
  task automatic test_auto_repeat();
    int k, d;
    logic [N-1:0]   el, ep, er, et;
    logic [4*N-1:0] got, exp;
    apply_reset();
    raw_in[0] = 1'b1;
    k = edge_cnt + 1;
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      d  = edge_cnt - k;
      el = {1'b0, (d >= 5 && d < 24)};
      ep = {1'b0, (d == 5)};
      er = {1'b0, (d == 24)};
      et = {1'b0, REP_EN && (d == 15 || d == 18 || d == 21)};
      got = {level_out, press_out, release_out, repeat_out};
      exp = {el, ep, er, et};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL auto_repeat d=%0d got=%b exp=%b", d, got, exp);
      end
      if (d == 18) raw_in[0] = 1'b0;
    end
  endtask

  task automatic test_simultaneous();
    int k, d;
    logic [N-1:0]   el, ep, er, et;
    logic [4*N-1:0] got, exp;
    apply_reset();
    raw_in = 2'b11;
    k = edge_cnt + 1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      d  = edge_cnt - k;
      el = {(d >= 5 && d < 13), (d >= 5 && d < 28)};
      ep = {(d == 5), (d == 5)};
      er = {(d == 13), (d == 28)};
      et = {1'b0, REP_EN && (d == 15 || d == 18 || d == 21 || d == 24 || d == 27)};
      got = {level_out, press_out, release_out, repeat_out};
      exp = {el, ep, er, et};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL simultaneous d=%0d got=%b exp=%b", d, got, exp);
      end
      if (d == 7)  raw_in[1] = 1'b0;
      if (d == 22) raw_in[0] = 1'b0;
    end
  endtask

  // Reset asserted over edges d=18,19 while in REPEAT; first post-reset
  // sample at d=20 gives a fresh press at d=25 and never a release.
  task automatic test_reset_mid_hold();
    int k, d;
    logic [N-1:0]   el, ep, er, et;
    logic [4*N-1:0] got, exp;
    apply_reset();
    raw_in[0] = 1'b1;
    k = edge_cnt + 1;
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      d  = edge_cnt - k;
      el = {1'b0, ((d >= 5 && d <= 17) || d >= 25)};
      ep = {1'b0, (d == 5 || d == 25)};
      er = '0;
      et = {1'b0, REP_EN && (d == 15)};
      got = {level_out, press_out, release_out, repeat_out};
      exp = {el, ep, er, et};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_mid_hold d=%0d got=%b exp=%b", d, got, exp);
      end
      if (d == 17) rst = 1'b1;
      if (d == 19) rst = 1'b0;
    end
    apply_reset();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_simultaneous();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_button_bank
`default_nettype wire
